// File: rtl/debug_mon_pkg.sv
// debug_mon_pkg
// Shared definitions for the debug monitor memory controller:
//   - mon_state_e : controller FSM state encoding
//   - JDO_*       : bit positions of the fields inside the 38-bit JTAG word
//   - BE_W        : number of byte lanes on the CPU slave port
`timescale 1ns/1ps
package debug_mon_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    J_RD  = 3'd1,
    J_CAP = 3'd2,
    J_WR  = 3'd3,
    C_RD  = 3'd4,
    C_RSP = 3'd5
  } mon_state_e;

  localparam int JDO_W        = 38;
  localparam int JDO_RD_BIT   = 34;  // request a JTAG read
  localparam int JDO_LD_BIT   = 35;  // load mon_addr from the address field
  localparam int JDO_CLR_BIT  = 36;  // clear the sticky monitor error
  localparam int JDO_ADDR_LSB = 25;  // LSB of the address field
  localparam int JDO_DATA_LSB = 3;   // LSB of the write-data field

  localparam int BE_W = 4;

endpackage

// File: rtl/debug_mon_ram.sv
// debug_mon_ram
// Single-port synchronous RAM, one-cycle read latency, byte-lane writes.
// Contents are never reset. The read is read-before-write.
// Ports:
//   clk      : clock
//   i_addr   : word address
//   i_we     : write enable
//   i_be     : byte-lane enables for the write
//   i_wdata  : write data
//   o_rdata  : registered read data (word at i_addr of the previous cycle)
`timescale 1ns/1ps
module debug_mon_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic [BE_W-1:0]   i_be,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  // Memory array: byte-lane write and registered read of the addressed word
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/debug_mon_mem_ctrl.sv
// debug_mon_mem_ctrl
// Debug monitor memory controller. A JTAG side (jdo + action strobes) and a
// CPU slave port share one single-port RAM. JTAG traffic always has priority;
// CPU requests colliding with it, or arriving while busy, are stalled.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   jdo                     : 38-bit JTAG data word
//   take_action_ocimem_a    : load address / start read / clear error
//   take_no_action_ocimem_a : auto-increment read
//   take_action_ocimem_b    : write jdo[34:3] at mon_addr, then increment
//   MonDReg                 : monitor data register
//   monitor_ready           : high when the controller is idle
//   monitor_error           : sticky flag for JTAG strobes received while busy
//   chipselect/read/write/address/writedata/byteenable : CPU request
//   readdata/waitrequest    : CPU response
`timescale 1ns/1ps
module debug_mon_mem_ctrl
  import debug_mon_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  input  logic [BE_W-1:0]   byteenable,
  output logic [DATA_W-1:0] readdata,
  output logic              waitrequest
);

  mon_state_e        r_state;
  mon_state_e        w_next_state;
  logic [ADDR_W-1:0] r_mon_addr;
  logic [DATA_W-1:0] r_mon_dreg;
  logic [DATA_W-1:0] r_readdata;
  logic [DATA_W-1:0] r_jdata;
  logic              r_error;
  logic              r_auto_inc;

  logic              w_jtag_any;
  logic              w_cpu_req;
  logic              w_cpu_wr;
  logic              w_cpu_rd;
  logic              w_ld_addr;
  logic              w_clr_err;
  logic              w_set_err;
  logic              w_waitrequest;
  logic              w_ram_we;
  logic [BE_W-1:0]   w_ram_be;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [DATA_W-1:0] w_ram_rdata;
  logic              w_unused_jdo;

  assign w_jtag_any   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign w_cpu_req    = chipselect & (read | write);
  assign w_cpu_wr     = chipselect & write;
  // write has precedence when read and write are both asserted
  assign w_cpu_rd     = chipselect & read & ~write;
  assign w_set_err    = (r_state != IDLE) & w_jtag_any;
  assign w_unused_jdo = ^{jdo[JDO_W-1], jdo[JDO_DATA_LSB-1:0]};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, RAM port steering and CPU handshake
  always_comb begin
    w_next_state  = r_state;
    w_waitrequest = w_cpu_req;
    w_ram_we      = 1'b0;
    w_ram_be      = {BE_W{1'b0}};
    w_ram_addr    = r_mon_addr;
    w_ram_wdata   = r_jdata;
    w_ld_addr     = 1'b0;
    w_clr_err     = 1'b0;
    case (r_state)
      IDLE: begin
        // the CPU address drives the RAM so an accepted read has data in C_RD
        w_ram_addr = address;
        if (take_action_ocimem_a) begin
          w_ld_addr = jdo[JDO_LD_BIT];
          w_clr_err = jdo[JDO_CLR_BIT];
          if (jdo[JDO_RD_BIT]) begin
            w_next_state = J_RD;
          end else begin
            w_next_state = IDLE;
          end
        end else if (take_no_action_ocimem_a) begin
          w_next_state = J_RD;
        end else if (take_action_ocimem_b) begin
          w_next_state = J_WR;
        end else if (w_cpu_wr) begin
          w_ram_we      = 1'b1;
          w_ram_be      = byteenable;
          w_ram_wdata   = writedata;
          w_waitrequest = 1'b0;
        end else if (w_cpu_rd) begin
          w_next_state  = C_RD;
          w_waitrequest = 1'b1;
        end else begin
          w_waitrequest = 1'b0;
        end
      end
      J_RD:  w_next_state = J_CAP;
      J_CAP: w_next_state = IDLE;
      J_WR: begin
        w_ram_we     = 1'b1;
        w_ram_be     = {BE_W{1'b1}};
        w_next_state = IDLE;
      end
      C_RD:  w_next_state = C_RSP;
      C_RSP: begin
        w_next_state  = IDLE;
        w_waitrequest = 1'b0;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Monitor address, latched JTAG data, auto-increment flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mon_addr <= {ADDR_W{1'b0}};
      r_jdata    <= {DATA_W{1'b0}};
      r_auto_inc <= 1'b0;
    end else begin
      if (w_ld_addr) begin
        r_mon_addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
      end else if ((r_state == J_WR) || ((r_state == J_CAP) && r_auto_inc)) begin
        // natural wrap from the all-ones address back to zero
        r_mon_addr <= r_mon_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      if ((r_state == IDLE) && (w_next_state == J_RD)) begin
        r_auto_inc <= ~take_action_ocimem_a;
      end
      if ((r_state == IDLE) && (w_next_state == J_WR)) begin
        r_jdata <= jdo[JDO_DATA_LSB +: DATA_W];
      end
    end
  end

  // Output data registers and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mon_dreg <= {DATA_W{1'b0}};
      r_readdata <= {DATA_W{1'b0}};
      r_error    <= 1'b0;
    end else begin
      if (r_state == J_CAP) begin
        r_mon_dreg <= w_ram_rdata;
      end else if (r_state == J_WR) begin
        r_mon_dreg <= r_jdata;
      end
      if (r_state == C_RD) begin
        r_readdata <= w_ram_rdata;
      end
      // a new error in the same cycle as a clear keeps the flag set
      if (w_set_err) begin
        r_error <= 1'b1;
      end else if (w_clr_err) begin
        r_error <= 1'b0;
      end
    end
  end

  debug_mon_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .BE_W   (BE_W)
  ) u_ram (
    .clk     (clk),
    .i_addr  (w_ram_addr),
    .i_we    (w_ram_we & ~reset),
    .i_be    (w_ram_be),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign MonDReg       = r_mon_dreg;
  assign readdata      = r_readdata;
  assign monitor_error = r_error;
  assign monitor_ready = (r_state == IDLE);
  assign waitrequest   = w_waitrequest;

endmodule

// File: tb/tb_debug_mon_mem_ctrl.sv
`timescale 1ns/1ps
module tb_debug_mon_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = 38'd0;
  logic        ta_a = 1'b0, tna_a = 1'b0, ta_b = 1'b0;
  logic        chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [7:0]  address = 8'd0;
  logic [31:0] writedata = 32'd0;
  logic [3:0]  byteenable = 4'd0;
  logic [31:0] MonDReg, readdata;
  logic        monitor_ready, monitor_error, waitrequest;

  debug_mon_mem_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(ta_a), .take_no_action_ocimem_a(tna_a),
    .take_action_ocimem_b(ta_b),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .chipselect(chipselect), .read(read), .write(write), .address(address),
    .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  // Behavioural model: memory image plus the architecturally visible values
  logic [31:0] mem [256];
  logic [7:0]  m_addr = 8'd0;
  logic [31:0] m_mond = 32'd0;
  logic [31:0] m_rdata = 32'd0;
  logic        m_err = 1'b0;
  logic        exp_ready = 1'b1;
  logic        exp_wait = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    check("MonDReg", MonDReg, m_mond);
    check("readdata", readdata, m_rdata);
    check("monitor_error", {31'd0, monitor_error}, {31'd0, m_err});
    check("monitor_ready", {31'd0, monitor_ready}, {31'd0, exp_ready});
    check("waitrequest", {31'd0, waitrequest}, {31'd0, exp_wait});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] mk_a(input logic ld, input logic [7:0] a,
                                       input logic rd, input logic clr);
    logic [37:0] j;
    j = 38'd0;
    j[35] = ld;
    j[34] = rd;
    j[36] = clr;
    j[32:25] = a;
    return j;
  endfunction

  // take_action_ocimem_a: optional address load, optional read, optional clear
  task automatic jtag_a(input logic ld, input logic [7:0] a, input logic rd, input logic clr);
    jdo = mk_a(ld, a, rd, clr);
    ta_a = 1'b1;
    tick();
    ta_a = 1'b0;
    if (ld) m_addr = a;
    if (clr) m_err = 1'b0;
    if (rd) begin
      exp_ready = 1'b0;
      tick();
      tick();
      m_mond = mem[m_addr];
      exp_ready = 1'b1;
    end
  endtask

  task automatic jtag_auto();
    tna_a = 1'b1;
    tick();
    tna_a = 1'b0;
    exp_ready = 1'b0;
    tick();
    tick();
    m_mond = mem[m_addr];
    m_addr = m_addr + 8'd1;
    exp_ready = 1'b1;
  endtask

  task automatic jtag_wr(input logic [31:0] d);
    jdo = {3'b000, d, 3'b000};
    ta_b = 1'b1;
    tick();
    ta_b = 1'b0;
    exp_ready = 1'b0;
    tick();
    mem[m_addr] = d;
    m_mond = d;
    m_addr = m_addr + 8'd1;
    exp_ready = 1'b1;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic also_rd);
    chipselect = 1'b1; write = 1'b1; read = also_rd;
    address = a; writedata = d; byteenable = be;
    exp_wait = 1'b0;
    tick();
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[a][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic cpu_rd(input logic [7:0] a);
    chipselect = 1'b1; read = 1'b1; address = a;
    exp_wait = 1'b1;
    tick();
    exp_ready = 1'b0;
    tick();
    exp_wait = 1'b0;
    m_rdata = mem[a];
    tick();
    chipselect = 1'b0; read = 1'b0;
    exp_ready = 1'b1;
  endtask

  task automatic apply_reset_model();
    m_addr = 8'd0; m_mond = 32'd0; m_rdata = 32'd0; m_err = 1'b0;
    exp_ready = 1'b1; exp_wait = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    check("reset MonDReg", MonDReg, 32'h0000_0000);
    check("reset ready", {31'd0, monitor_ready}, 32'd1);
    check("reset readdata", readdata, 32'h0000_0000);

    // Seed words used later
    cpu_wr(8'h00, 32'h0000_00AA, 4'hF, 1'b0);
    cpu_wr(8'h11, 32'hA5A5_0011, 4'hF, 1'b0);

    // Address load then JTAG write, mon_addr must advance to 0x11
    jtag_a(1'b1, 8'h10, 1'b0, 1'b0);
    jtag_wr(32'hDEAD_BEEF);
    check("jtag write MonDReg", MonDReg, 32'hDEAD_BEEF);
    jtag_auto();
    check("post-write addr 0x11", MonDReg, 32'hA5A5_0011);

    // Auto-increment read of 0x10
    jtag_a(1'b1, 8'h10, 1'b0, 1'b0);
    jtag_auto();
    check("auto read 0x10", MonDReg, 32'hDEAD_BEEF);
    jtag_auto();
    check("auto read 0x11", MonDReg, 32'hA5A5_0011);

    // Explicit read via jdo[34]
    jtag_a(1'b1, 8'h10, 1'b1, 1'b0);
    check("explicit read 0x10", MonDReg, 32'hDEAD_BEEF);

    // Address wrap 0xFF -> 0x00
    jtag_a(1'b1, 8'hFF, 1'b0, 1'b0);
    jtag_wr(32'h0000_0001);
    jtag_auto();
    check("wrap read 0x00", MonDReg, 32'h0000_00AA);
    cpu_rd(8'hFF);
    check("cpu read 0xFF", readdata, 32'h0000_0001);

    // CPU byte-enable write (second one with read asserted too)
    cpu_wr(8'h20, 32'hFFFF_FFFF, 4'hF, 1'b0);
    cpu_wr(8'h20, 32'h1234_5678, 4'b0011, 1'b1);
    cpu_rd(8'h20);
    check("cpu byteenable read", readdata, 32'hFFFF_5678);

    // Collision: JTAG read and CPU read together, extra strobe while busy
    jdo = mk_a(1'b1, 8'h10, 1'b1, 1'b0);
    ta_a = 1'b1;
    chipselect = 1'b1; read = 1'b1; address = 8'h11;
    exp_wait = 1'b1;
    tick();
    ta_a = 1'b0;
    m_addr = 8'h10;
    exp_ready = 1'b0;
    tna_a = 1'b1;
    tick();
    tna_a = 1'b0;
    m_err = 1'b1;
    tick();
    m_mond = mem[8'h10];
    exp_ready = 1'b1;
    tick();
    exp_ready = 1'b0;
    tick();
    exp_wait = 1'b0;
    m_rdata = mem[8'h11];
    tick();
    chipselect = 1'b0; read = 1'b0;
    exp_ready = 1'b1;
    check("collision MonDReg", MonDReg, 32'hDEAD_BEEF);
    check("collision readdata", readdata, 32'hA5A5_0011);
    check("collision error", {31'd0, monitor_error}, 32'd1);
    jtag_a(1'b0, 8'h00, 1'b0, 1'b1);
    check("error cleared", {31'd0, monitor_error}, 32'd0);

    // Reset during J_RD
    jdo = mk_a(1'b1, 8'h11, 1'b1, 1'b0);
    ta_a = 1'b1;
    tick();
    ta_a = 1'b0;
    exp_ready = 1'b0;
    reset = 1'b1;
    apply_reset_model();
    tick();
    reset = 1'b0;
    check("reset in J_RD MonDReg", MonDReg, 32'h0000_0000);
    cpu_rd(8'h20);
    check("RAM kept after reset", readdata, 32'hFFFF_5678);

    // Reset during J_WR: the write to 0x00 must be abandoned
    jdo = {3'b000, 32'hBAD0_BAD0, 3'b000};
    ta_b = 1'b1;
    tick();
    ta_b = 1'b0;
    exp_ready = 1'b0;
    reset = 1'b1;
    apply_reset_model();
    tick();
    reset = 1'b0;
    cpu_rd(8'h00);
    check("aborted J_WR no write", readdata, 32'h0000_00AA);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
